// File: rtl/carfield_cfg_regs.sv
//==============================================================================
// Module      : carfield_cfg_regs
// Description : Read-only register block publishing the elaborated Carfield
//               build configuration; optional power-on signature walker is
//               enabled with `define CARFIELD_CFG_SIG_EN.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

package carfield_pkg;

    typedef logic [63:0] doub_bt;

    typedef struct packed {
        logic        Bootrom;
        logic        Uart;
        logic        I2c;
        logic        SpiHost;
        logic        Gpio;
        logic        Dma;
        logic        SerialLink;
        logic        Vga;
        logic        LlcNotBypass;
        logic        DualCore;
        logic [31:0] AddrWidth;
        logic [31:0] AxiDataWidth;
        logic [31:0] AxiUserWidth;
        logic [31:0] AxiMstIdWidth;
        logic [31:0] LlcSetAssoc;
        logic [31:0] LlcNumLines;
        logic [31:0] LlcNumBlocks;
        logic [31:0] RtcFreq;
        doub_bt      LlcOutRegionStart;
        doub_bt      LlcOutRegionEnd;
        doub_bt      SlinkRegionStart;
        doub_bt      SlinkRegionEnd;
    } cheshire_cfg_t;

    localparam cheshire_cfg_t CarfieldCfgDefault = '{
        Bootrom:           1'b1,
        Uart:              1'b1,
        I2c:               1'b1,
        SpiHost:           1'b1,
        Gpio:              1'b1,
        Dma:               1'b1,
        SerialLink:        1'b1,
        Vga:               1'b1,
        LlcNotBypass:      1'b1,
        DualCore:          1'b0,
        AddrWidth:         32'd48,
        AxiDataWidth:      32'd64,
        AxiUserWidth:      32'd2,
        AxiMstIdWidth:     32'd2,
        LlcSetAssoc:       32'd8,
        LlcNumLines:       32'd256,
        LlcNumBlocks:      32'd8,
        RtcFreq:           32'd32768,
        LlcOutRegionStart: 64'h0000_0000_8000_0000,
        LlcOutRegionEnd:   64'h0000_0001_0000_0000,
        SlinkRegionStart:  64'h0000_0001_0000_0000,
        SlinkRegionEnd:    64'h0000_0002_0000_0000
    };

endpackage

module carfield_cfg_regs #(
    parameter carfield_pkg::cheshire_cfg_t Cfg       = carfield_pkg::CarfieldCfgDefault,
    parameter int                          AddrWidth = 32,
    parameter logic [31:0]                 HwVersion = 32'h0001_0000
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 req_valid_i,
    output logic                 req_ready_o,
    input  logic                 req_write_i,
    input  logic [AddrWidth-1:0] req_addr_i,
    input  logic [31:0]          req_wdata_i,
    output logic                 rsp_valid_o,
    input  logic                 rsp_ready_i,
    output logic [31:0]          rsp_rdata_o,
    output logic                 rsp_error_o,
    output logic                 sig_valid_o
);

    localparam logic [63:0] LLC_BYTES = 64'(Cfg.LlcSetAssoc) * 64'(Cfg.LlcNumLines)
                                      * 64'(Cfg.LlcNumBlocks) * 64'(Cfg.AxiDataWidth) / 64'd8;

    // Constant part of the map; word 15 is supplied separately.
    function automatic logic [31:0] cfg_word(input logic [3:0] idx);
        logic [31:0] w;
        w = '0;
        case (idx)
            4'd0:  w = 32'hCA5F_1E1D;
            4'd1:  w = HwVersion;
            4'd2:  w = {22'd0, Cfg.DualCore, Cfg.LlcNotBypass, Cfg.Vga, Cfg.SerialLink,
                        Cfg.Dma, Cfg.Gpio, Cfg.SpiHost, Cfg.I2c, Cfg.Uart, Cfg.Bootrom};
            4'd3:  w = {Cfg.AxiMstIdWidth[7:0], Cfg.AxiUserWidth[7:0],
                        Cfg.AxiDataWidth[7:0], Cfg.AddrWidth[7:0]};
            4'd4:  w = Cfg.LlcOutRegionStart[31:0];
            4'd5:  w = Cfg.LlcOutRegionStart[63:32];
            4'd6:  w = Cfg.LlcOutRegionEnd[31:0];
            4'd7:  w = Cfg.LlcOutRegionEnd[63:32];
            4'd8:  w = Cfg.SlinkRegionStart[31:0];
            4'd9:  w = Cfg.SlinkRegionStart[63:32];
            4'd10: w = Cfg.SlinkRegionEnd[31:0];
            4'd11: w = Cfg.SlinkRegionEnd[63:32];
            4'd12: w = Cfg.RtcFreq;
            4'd13: w = LLC_BYTES[31:0];
            default: w = '0;
        endcase
        return w;
    endfunction

    logic [3:0]  w_word_idx;
    logic        w_err;
    logic        w_stall;
    logic [31:0] w_sig_word;
    logic [31:0] w_rdata;
    logic        w_accept;
    logic        unused_wdata;

    logic        rsp_valid_q, rsp_valid_d;
    logic [31:0] rsp_rdata_q, rsp_rdata_d;
    logic        rsp_error_q, rsp_error_d;

    assign unused_wdata = ^req_wdata_i;
    assign w_word_idx   = req_addr_i[5:2];
    assign w_err        = req_write_i | (req_addr_i[1:0] != 2'b00) | ((req_addr_i >> 6) != '0);

`ifdef CARFIELD_CFG_SIG_EN
    typedef enum logic [0:0] {
        SIG_RUN  = 1'b0,
        SIG_DONE = 1'b1
    } sig_state_e;

    sig_state_e  sig_state_q, sig_state_d;
    logic [3:0]  sig_idx_q, sig_idx_d;
    logic [31:0] sig_acc_q, sig_acc_d;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            sig_state_q <= SIG_RUN;
            sig_idx_q   <= 4'd0;
            sig_acc_q   <= 32'hFFFF_FFFF;
        end else begin
            sig_state_q <= sig_state_d;
            sig_idx_q   <= sig_idx_d;
            sig_acc_q   <= sig_acc_d;
        end
    end

    always_comb begin
        sig_state_d = sig_state_q;
        sig_idx_d   = sig_idx_q;
        sig_acc_d   = sig_acc_q;
        case (sig_state_q)
            SIG_RUN: begin
                sig_acc_d = {sig_acc_q[30:0], sig_acc_q[31]} ^ cfg_word(sig_idx_q);
                sig_idx_d = sig_idx_q + 4'd1;
                if (sig_idx_q == 4'd14) begin
                    sig_state_d = SIG_DONE;
                end
            end
            default: ;
        endcase
    end

    // Only a legal read of the signature word waits for the walker.
    assign w_stall     = (sig_state_q == SIG_RUN) & req_valid_i & ~w_err & (w_word_idx == 4'd15);
    assign w_sig_word  = sig_acc_q;
    assign sig_valid_o = (sig_state_q == SIG_DONE);
`else
    assign w_stall     = 1'b0;
    assign w_sig_word  = 32'd0;
    assign sig_valid_o = 1'b1;
`endif

    assign req_ready_o = (~rsp_valid_q | rsp_ready_i) & ~w_stall;
    assign w_accept    = req_valid_i & req_ready_o;
    assign w_rdata     = (w_word_idx == 4'd15) ? w_sig_word : cfg_word(w_word_idx);

    always_comb begin
        rsp_valid_d = rsp_valid_q;
        rsp_rdata_d = rsp_rdata_q;
        rsp_error_d = rsp_error_q;
        if (rsp_valid_q & rsp_ready_i) begin
            rsp_valid_d = 1'b0;
        end
        if (w_accept) begin
            rsp_valid_d = 1'b1;
            rsp_error_d = w_err;
            rsp_rdata_d = w_err ? 32'd0 : w_rdata;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= 32'd0;
            rsp_error_q <= 1'b0;
        end else begin
            rsp_valid_q <= rsp_valid_d;
            rsp_rdata_q <= rsp_rdata_d;
            rsp_error_q <= rsp_error_d;
        end
    end

    assign rsp_valid_o = rsp_valid_q;
    assign rsp_rdata_o = rsp_rdata_q;
    assign rsp_error_o = rsp_error_q;

endmodule

`default_nettype wire

// File: tb/tb_carfield_cfg_regs.sv
//==============================================================================
// Module      : tb_carfield_cfg_regs
// Description : Scoreboard bench for carfield_cfg_regs (either setting of
//               CARFIELD_CFG_SIG_EN).
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_carfield_cfg_regs;

    logic        clk_i = 1'b0;
    logic        rst_i = 1'b1;
    logic        req_valid_i = 1'b0;
    logic        req_ready_o;
    logic        req_write_i = 1'b0;
    logic [31:0] req_addr_i = 32'd0;
    logic [31:0] req_wdata_i = 32'd0;
    logic        rsp_valid_o;
    logic        rsp_ready_i = 1'b1;
    logic [31:0] rsp_rdata_o;
    logic        rsp_error_o;
    logic        sig_valid_o;

    carfield_cfg_regs dut (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .req_valid_i (req_valid_i),
        .req_ready_o (req_ready_o),
        .req_write_i (req_write_i),
        .req_addr_i  (req_addr_i),
        .req_wdata_i (req_wdata_i),
        .rsp_valid_o (rsp_valid_o),
        .rsp_ready_i (rsp_ready_i),
        .rsp_rdata_o (rsp_rdata_o),
        .rsp_error_o (rsp_error_o),
        .sig_valid_o (sig_valid_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct packed {
        logic [31:0] data;
        logic        err;
    } exp_t;

    int          total = 0;
    int          bad   = 0;
    exp_t        sb[$];
    logic [31:0] exp_words[16];

`ifdef CARFIELD_CFG_SIG_EN
    localparam bit SIG_EN = 1'b1;
`else
    localparam bit SIG_EN = 1'b0;
`endif

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic exp_t model(input logic [31:0] a, input logic w);
        exp_t e;
        e.err  = w | (a[1:0] != 2'b00) | ((a >> 6) != 32'd0);
        e.data = e.err ? 32'd0 : exp_words[a[5:2]];
        return e;
    endfunction

    // Response checker: every cycle a response is visible it must match the
    // oldest outstanding expectation (this also proves it is held stable).
    always @(negedge clk_i) begin
        if (rst_i) begin
            sb.delete();
        end else begin
            if (rsp_valid_o) begin
                if (sb.size() == 0) begin
                    chk("rsp_unexpected", 32'd1, 32'd0);
                end else begin
                    chk("rsp_rdata", rsp_rdata_o, sb[0].data);
                    chk("rsp_error", {31'd0, rsp_error_o}, {31'd0, sb[0].err});
                    if (rsp_ready_i) void'(sb.pop_front());
                end
            end
            if (req_valid_i && req_ready_o) begin
                if (!req_write_i && req_addr_i == 32'h3C)
                    chk("w15_accept_sig_valid", {31'd0, sig_valid_o}, 32'd1);
                sb.push_back(model(req_addr_i, req_write_i));
            end
        end
    end

    task automatic issue(input logic [31:0] a, input logic w);
        req_valid_i = 1'b1;
        req_addr_i  = a;
        req_write_i = w;
        req_wdata_i = 32'hDEAD_BEEF;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk_i);
            if (req_ready_o) break;
        end
        chk("accept_timeout", {31'd0, req_ready_o}, 32'd1);
        @(posedge clk_i);
        #1;
        req_valid_i = 1'b0;
        req_write_i = 1'b0;
    endtask

    task automatic drain();
        for (int i = 0; i < 100; i++) begin
            if (sb.size() == 0) break;
            @(posedge clk_i);
            #1;
        end
        chk("drain_timeout", sb.size(), 32'd0);
    endtask

    initial begin
        logic [31:0] acc;
        logic [31:0] b2b_addrs[5];
        int          cnt;

        exp_words[0]  = 32'hCA5F_1E1D;
        exp_words[1]  = 32'h0001_0000;
        exp_words[2]  = 32'h0000_01FF;
        exp_words[3]  = 32'h0202_4030;
        exp_words[4]  = 32'h8000_0000;
        exp_words[5]  = 32'h0000_0000;
        exp_words[6]  = 32'h0000_0000;
        exp_words[7]  = 32'h0000_0001;
        exp_words[8]  = 32'h0000_0000;
        exp_words[9]  = 32'h0000_0001;
        exp_words[10] = 32'h0000_0000;
        exp_words[11] = 32'h0000_0002;
        exp_words[12] = 32'h0000_8000;
        exp_words[13] = 32'h0002_0000;
        exp_words[14] = 32'h0000_0000;
        acc = 32'hFFFF_FFFF;
        for (int i = 0; i < 15; i++) acc = {acc[30:0], acc[31]} ^ exp_words[i];
        exp_words[15] = SIG_EN ? acc : 32'd0;

        // Reset state
        rst_i = 1'b1;
        repeat (2) @(posedge clk_i);
        #1 rst_i = 1'b0;
        @(negedge clk_i);
        chk("rst_rsp_valid", {31'd0, rsp_valid_o}, 32'd0);
        chk("rst_rsp_rdata", rsp_rdata_o, 32'd0);
        chk("rst_rsp_error", {31'd0, rsp_error_o}, 32'd0);
        chk("rst_req_ready", {31'd0, req_ready_o}, 32'd1);
        chk("rst_sig_valid", {31'd0, sig_valid_o}, SIG_EN ? 32'd0 : 32'd1);

        // Signature read one cycle after reset
        @(posedge clk_i);
        #1;
        issue(32'h3C, 1'b0);
        chk("sig_valid_after_w15", {31'd0, sig_valid_o}, 32'd1);
        drain();

        // Whole map
        for (int k = 0; k < 16; k++) issue(32'(k * 4), 1'b0);
        drain();

        // Error responses, then a normal read
        issue(32'h00, 1'b1);
        issue(32'h02, 1'b0);
        issue(32'h40, 1'b0);
        issue(32'h3C, 1'b1);
        issue(32'h100, 1'b0);
        issue(32'h00, 1'b0);
        drain();

        // Response back-pressure
        rsp_ready_i = 1'b0;
        req_valid_i = 1'b1;
        req_addr_i  = 32'h08;
        req_write_i = 1'b0;
        @(negedge clk_i);
        chk("bp_first_ready", {31'd0, req_ready_o}, 32'd1);
        @(posedge clk_i);
        #1 req_addr_i = 32'h34;
        repeat (5) begin
            @(negedge clk_i);
            chk("bp_stall_ready", {31'd0, req_ready_o}, 32'd0);
        end
        @(posedge clk_i);
        #1 rsp_ready_i = 1'b1;
        @(negedge clk_i);
        chk("bp_release_ready", {31'd0, req_ready_o}, 32'd1);
        @(posedge clk_i);
        #1 req_valid_i = 1'b0;
        drain();

        // One request per cycle
        b2b_addrs[0] = 32'h04;
        b2b_addrs[1] = 32'h0C;
        b2b_addrs[2] = 32'h30;
        b2b_addrs[3] = 32'h38;
        b2b_addrs[4] = 32'h41;
        req_valid_i = 1'b1;
        for (int k = 0; k < 5; k++) begin
            req_addr_i = b2b_addrs[k];
            @(negedge clk_i);
            chk("b2b_ready", {31'd0, req_ready_o}, 32'd1);
            @(posedge clk_i);
            #1;
        end
        req_valid_i = 1'b0;
        drain();

        // Reset with a response pending and the walker mid-way (idx 7)
        rst_i = 1'b1;
        @(posedge clk_i);
        #1 rst_i = 1'b0;
        rsp_ready_i = 1'b0;
        req_valid_i = 1'b1;
        req_addr_i  = 32'h00;
        @(posedge clk_i);
        #1 req_valid_i = 1'b0;
        repeat (6) @(posedge clk_i);
        #1 rst_i = 1'b1;
        @(posedge clk_i);
        #1 rst_i = 1'b0;
        @(negedge clk_i);
        chk("rst2_rsp_valid", {31'd0, rsp_valid_o}, 32'd0);
        chk("rst2_req_ready", {31'd0, req_ready_o}, 32'd1);
        rsp_ready_i = 1'b1;
        cnt = 0;
        for (int i = 0; i < 40; i++) begin
            if (sig_valid_o) break;
            @(negedge clk_i);
            cnt++;
        end
        chk("sig_latency", 32'(cnt), SIG_EN ? 32'd15 : 32'd0);

        // Signature recomputed identically after the second reset
        @(posedge clk_i);
        #1;
        issue(32'h3C, 1'b0);
        drain();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
